// File: rtl/rmt_page_tbl_pkg.sv
// Shared page-table definitions: FSM encoding, table geometry,
// VLAN index slice and the write-index range helper.
package rmt_page_tbl_pkg;

  localparam int PAGE_W         = 16;
  localparam int PAGE_TBL_DEPTH = 32;
  localparam int VLAN_IDX_LSB   = 4;
  localparam int VLAN_IDX_MSB   = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_OUT      = 3'd4
  } pt_state_e;

  // A control-path index addresses a real entry only below the depth.
  function automatic logic idx_in_range(input logic [7:0] idx);
    return int'(idx) < PAGE_TBL_DEPTH;
  endfunction

endpackage

// File: rtl/page_tbl_starve_cnt.sv
// Two-requester arbiter: the high-priority side wins unless the
// low side has lost LIMIT times in a row while waiting.
module page_tbl_starve_cnt #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en_i,
  input  logic hi_valid_i,
  input  logic lo_valid_i,
  output logic hi_grant_o,
  output logic lo_grant_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic       starved;

  assign starved    = lo_valid_i && (cnt_q == 4'(LIMIT));
  assign hi_grant_o = arb_en_i && hi_valid_i && !starved;
  assign lo_grant_o = arb_en_i && lo_valid_i && !hi_grant_o;

  // Count lost arbitrations, saturate at LIMIT, clear on a low grant.
  always_comb begin
    cnt_d = cnt_q;
    if (lo_grant_o) begin
      cnt_d = '0;
    end else if (hi_grant_o && lo_valid_i && !starved) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/page_tbl_arbiter.sv
// Page-table controller sharing one single-port RAM between config
// writes and VLAN lookups. Optional counters: PAGE_TBL_ARB_STATS_EN.
module page_tbl_arbiter #(
  parameter int PAGE_W       = rmt_page_tbl_pkg::PAGE_W,
  parameter int ADDR_W       = 5,
  parameter int VLAN_W       = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [VLAN_W-1:0] vlan_in,
  input  logic              vlan_valid_in,
  output logic              vlan_ready_out,
  input  logic [7:0]        cfg_index,
  input  logic [PAGE_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              cfg_err,
  output logic [PAGE_W-1:0] page_out,
  output logic              page_valid_out,
  input  logic              page_ready_in,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr_en,
  output logic [PAGE_W-1:0] ram_wr_data,
  output logic              ram_rd_en,
  input  logic [PAGE_W-1:0] ram_rd_data,
  output logic [31:0]       stat_lookups,
  output logic [31:0]       stat_writes,
  output logic [31:0]       stat_stalls
);

  import rmt_page_tbl_pkg::*;

  pt_state_e         state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [PAGE_W-1:0] wdata_q;
  logic [PAGE_W-1:0] page_q;
  logic              wr_en_q;
  logic              rd_en_q;
  logic              pvalid_q;
  logic              err_q;

  logic              arb_en;
  logic              wr_gnt;
  logic              rd_gnt;
  logic [ADDR_W-1:0] vlan_addr;
  logic              unused_vlan;

  assign arb_en      = (state_q == ST_IDLE) && !rst;
  assign vlan_addr   = ADDR_W'(vlan_in[VLAN_IDX_MSB:VLAN_IDX_LSB]);
  assign unused_vlan = ^vlan_in;

  page_tbl_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .rst        (rst),
    .arb_en_i   (arb_en),
    .hi_valid_i (cfg_valid),
    .lo_valid_i (vlan_valid_in),
    .hi_grant_o (wr_gnt),
    .lo_grant_o (rd_gnt)
  );

  assign cfg_ready      = wr_gnt;
  assign vlan_ready_out = rd_gnt;
  assign cfg_err        = err_q;
  assign page_out       = page_q;
  assign page_valid_out = pvalid_q;
  assign ram_addr       = addr_q;
  assign ram_wr_en      = wr_en_q;
  assign ram_wr_data    = wdata_q;
  assign ram_rd_en      = rd_en_q;

  // Access sequencer with registered RAM strobes and page output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      page_q   <= '0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      pvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (wr_gnt) begin
            if (idx_in_range(cfg_index)) begin
              state_q <= ST_WR;
              wr_en_q <= 1'b1;
              addr_q  <= cfg_index[ADDR_W-1:0];
              wdata_q <= cfg_data;
            end else begin
              err_q <= 1'b1;
            end
          end else if (rd_gnt) begin
            state_q <= ST_RD_ISSUE;
            rd_en_q <= 1'b1;
            addr_q  <= vlan_addr;
          end
        end
        ST_WR:       state_q <= ST_IDLE;
        ST_RD_ISSUE: state_q <= ST_RD_WAIT;
        ST_RD_WAIT: begin
          page_q   <= ram_rd_data;
          pvalid_q <= 1'b1;
          state_q  <= ST_OUT;
        end
        ST_OUT: begin
          if (page_ready_in) begin
            pvalid_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef PAGE_TBL_ARB_STATS_EN
  logic [31:0] lookups_q;
  logic [31:0] writes_q;
  logic [31:0] stalls_q;

  // Free-running activity counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      lookups_q <= '0;
      writes_q  <= '0;
      stalls_q  <= '0;
    end else begin
      if (rd_gnt)
        lookups_q <= lookups_q + 32'd1;
      if (state_q == ST_WR)
        writes_q <= writes_q + 32'd1;
      if (state_q == ST_OUT && !page_ready_in)
        stalls_q <= stalls_q + 32'd1;
    end
  end

  assign stat_lookups = lookups_q;
  assign stat_writes  = writes_q;
  assign stat_stalls  = stalls_q;
`else
  assign stat_lookups = '0;
  assign stat_writes  = '0;
  assign stat_stalls  = '0;
`endif

endmodule

// File: tb/tb_page_tbl_arbiter.sv
// Bench for page_tbl_arbiter: transaction-level reference model
// checked every cycle, directed scenarios, then random traffic.
module tb_page_tbl_arbiter;

  localparam int LIMIT = 4;
`ifdef PAGE_TBL_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] vlan_in;
  logic        vlan_valid_in;
  logic        vlan_ready_out;
  logic [7:0]  cfg_index;
  logic [15:0] cfg_data;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        cfg_err;
  logic [15:0] page_out;
  logic        page_valid_out;
  logic        page_ready_in;
  logic [4:0]  ram_addr;
  logic        ram_wr_en;
  logic [15:0] ram_wr_data;
  logic        ram_rd_en;
  logic [15:0] ram_rd_data = '0;
  logic [31:0] stat_lookups;
  logic [31:0] stat_writes;
  logic [31:0] stat_stalls;

  always #5 clk = ~clk;

  page_tbl_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .vlan_in        (vlan_in),
    .vlan_valid_in  (vlan_valid_in),
    .vlan_ready_out (vlan_ready_out),
    .cfg_index      (cfg_index),
    .cfg_data       (cfg_data),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_err        (cfg_err),
    .page_out       (page_out),
    .page_valid_out (page_valid_out),
    .page_ready_in  (page_ready_in),
    .ram_addr       (ram_addr),
    .ram_wr_en      (ram_wr_en),
    .ram_wr_data    (ram_wr_data),
    .ram_rd_en      (ram_rd_en),
    .ram_rd_data    (ram_rd_data),
    .stat_lookups   (stat_lookups),
    .stat_writes    (stat_writes),
    .stat_stalls    (stat_stalls)
  );

  logic [15:0] mem [32];

  initial for (int i = 0; i < 32; i++) mem[i] = '0;

  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_addr] <= ram_wr_data;
    if (ram_rd_en) ram_rd_data <= mem[ram_addr];
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: op kind 0 none, 1 write, 2 lookup; age counts
  // cycles since the accept.
  bit          m_init = 1'b0;
  int          m_kind, m_age, m_starve;
  bit          m_err;
  logic [15:0] m_page, m_pend, m_wdata;
  logic [4:0]  m_addr;
  logic [31:0] m_sl, m_sw, m_ss;
  logic [15:0] ref_mem [32];
  bit          e_cw, e_vr;

  initial for (int i = 0; i < 32; i++) ref_mem[i] = '0;

  always @(negedge clk) begin
    e_cw = !rst && m_kind == 0 && cfg_valid &&
           !(vlan_valid_in && m_starve == LIMIT);
    e_vr = !rst && m_kind == 0 && vlan_valid_in && !e_cw;
    if (m_init) begin
      chk("cfg_ready", cfg_ready, e_cw);
      chk("vlan_ready", vlan_ready_out, e_vr);
      chk("ram_wr_en", ram_wr_en, m_kind == 1);
      chk("ram_rd_en", ram_rd_en, m_kind == 2 && m_age == 1);
      chk("page_valid", page_valid_out, m_kind == 2 && m_age == 3);
      chk("page_out", page_out, m_page);
      chk("ram_addr", ram_addr, m_addr);
      chk("ram_wr_data", ram_wr_data, m_wdata);
      chk("cfg_err", cfg_err, m_err);
      chk("stat_lookups", stat_lookups, STATS ? m_sl : 0);
      chk("stat_writes", stat_writes, STATS ? m_sw : 0);
      chk("stat_stalls", stat_stalls, STATS ? m_ss : 0);
    end
    if (rst) begin
      m_init = 1'b1; m_kind = 0; m_age = 0; m_starve = 0;
      m_err = 0; m_page = '0; m_pend = '0; m_wdata = '0;
      m_addr = '0; m_sl = 0; m_sw = 0; m_ss = 0;
    end else if (m_init) begin
      m_err = 0;
      if (m_kind == 0) begin
        if (e_cw) begin
          if (cfg_index[7:5] == 3'b0) begin
            m_kind = 1;
            m_addr = cfg_index[4:0];
            m_wdata = cfg_data;
            ref_mem[cfg_index[4:0]] = cfg_data;
          end else begin
            m_err = 1;
          end
          if (vlan_valid_in && m_starve < LIMIT) m_starve++;
        end else if (e_vr) begin
          m_kind = 2;
          m_age = 1;
          m_addr = vlan_in[8:4];
          m_pend = ref_mem[vlan_in[8:4]];
          m_starve = 0;
          m_sl++;
        end
      end else if (m_kind == 1) begin
        m_kind = 0;
        m_sw++;
      end else if (m_age < 3) begin
        m_age++;
        if (m_age == 3) m_page = m_pend;
      end else if (page_ready_in) begin
        m_kind = 0;
      end else begin
        m_ss++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input bit lookup, output int waited);
    bit got = 0;
    waited = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = lookup ? vlan_ready_out : cfg_ready;
      if (got) waited = i;
      cyc();
    end
    if (!got) chk("grant_timeout", 0, 1);
  endtask

  task automatic do_lookup(input logic [11:0] v, output logic [15:0] pg);
    int w;
    bit got = 0;
    pg = '0;
    vlan_in = v;
    vlan_valid_in = 1;
    wait_gnt(1, w);
    vlan_valid_in = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (page_valid_out) begin
        got = 1;
        pg = page_out;
        chk("lookup_latency", i, 2);
      end
      cyc();
    end
    if (!got) chk("page_timeout", 0, 1);
  endtask

  initial begin
    int w, nwr;
    bit got, hs_c, hs_v;
    logic [15:0] p;
    logic [31:0] s0;
    rst = 1; vlan_in = '0; vlan_valid_in = 0;
    cfg_index = '0; cfg_data = '0; cfg_valid = 1;
    page_ready_in = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_page_valid", page_valid_out, 0);
    chk("rst_wr_en", ram_wr_en, 0);
    cyc();
    rst = 0;

    cfg_valid = 1; cfg_index = 8'h03; cfg_data = 16'hBEEF;
    wait_gnt(0, w);
    chk("first_write_wait", w, 0);
    cfg_valid = 0;
    @(negedge clk);
    chk("wr_en_in_wr", ram_wr_en, 1);
    chk("wr_addr", ram_addr, 3);
    chk("wr_data", ram_wr_data, 16'hBEEF);
    cyc();
    @(negedge clk);
    chk("wr_en_one_cycle", ram_wr_en, 0);
    cyc();
    do_lookup(12'h035, p);
    chk("lookup_beef", p, 16'hBEEF);

    cfg_valid = 1; cfg_index = 8'h05; cfg_data = 16'h5555;
    wait_gnt(0, w);
    cfg_index = 8'h25; cfg_data = 16'h1234;
    wait_gnt(0, w);
    cfg_valid = 0;
    @(negedge clk);
    chk("oor_err_pulse", cfg_err, 1);
    chk("oor_no_write", ram_wr_en, 0);
    cyc();
    @(negedge clk);
    chk("oor_err_once", cfg_err, 0);
    cyc();
    chk("entry5_kept", mem[5], 16'h5555);
    do_lookup(12'h050, p);
    chk("lookup_5555", p, 16'h5555);

    cfg_valid = 1; cfg_index = 8'h01; cfg_data = 16'h0101;
    vlan_valid_in = 1; vlan_in = 12'h010;
    nwr = 0; got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (vlan_ready_out) got = 1;
      else if (cfg_ready) nwr++;
      cyc();
      if (got) vlan_valid_in = 0;
    end
    chk("starve_granted", got, 1);
    chk("starve_writes", nwr, 4);
    wait_gnt(0, w);
    chk("write_resume_wait", w, 3);
    cfg_valid = 0;
    cyc();

    s0 = stat_stalls;
    page_ready_in = 0;
    vlan_valid_in = 1; vlan_in = 12'h035;
    wait_gnt(1, w);
    vlan_valid_in = 0;
    cfg_valid = 1; cfg_index = 8'h02; cfg_data = 16'h2222;
    cyc();
    cyc();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", page_valid_out, 1);
      chk("stall_page", page_out, 16'hBEEF);
      chk("stall_no_grant", cfg_ready, 0);
      cyc();
    end
    page_ready_in = 1;
    @(negedge clk);
    chk("stall_count", stat_stalls - s0, STATS ? 5 : 0);
    cyc();
    wait_gnt(0, w);
    cfg_valid = 0;
    cyc();

    vlan_valid_in = 1; vlan_in = 12'h035;
    wait_gnt(1, w);
    vlan_valid_in = 0;
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    @(negedge clk);
    chk("rstmid_valid", page_valid_out, 0);
    chk("rstmid_page", page_out, 0);
    chk("rstmid_addr", ram_addr, 0);
    chk("rstmid_rd_en", ram_rd_en, 0);
    chk("rstmid_lookups", stat_lookups, 0);
    cyc();
    repeat (3) begin
      @(negedge clk);
      chk("rstmid_no_valid", page_valid_out, 0);
      cyc();
    end
    do_lookup(12'h035, p);
    chk("post_rst_lookup", p, 16'hBEEF);

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      hs_c = cfg_valid && cfg_ready;
      hs_v = vlan_valid_in && vlan_ready_out;
      cyc();
      if (rst) rst = 0;
      else if ($urandom_range(0, 299) == 0) rst = 1;
      if (!cfg_valid || hs_c) begin
        cfg_valid = ($urandom_range(0, 2) != 0);
        cfg_index = $urandom_range(0, 1) ? 8'($urandom_range(0, 31))
                                         : 8'($urandom);
        cfg_data = 16'($urandom);
      end
      if (!vlan_valid_in || hs_v) begin
        vlan_valid_in = ($urandom_range(0, 1) != 0);
        vlan_in = 12'($urandom);
      end
      page_ready_in = ($urandom_range(0, 3) != 0);
    end

    cfg_valid = 0; vlan_valid_in = 0; page_ready_in = 1; rst = 0;
    repeat (10) cyc();
`ifndef PAGE_TBL_ARB_STATS_EN
    chk("stats_off_lookups", stat_lookups, 0);
    chk("stats_off_writes", stat_writes, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/page_tbl_arbiter.md
# page_tbl_arbiter

Single-port page-table controller for an action-engine stage. It shares one 32-entry × 16-bit page-table RAM between two requesters: control-path configuration writes and datapath VLAN lookups. It sequences each RAM access and returns the looked-up page base to the stateful ALUs through a valid/ready handshake. Writes normally win arbitration; a starvation counter guarantees that lookups still make progress.

## Interface
- `PAGE_W`, 16, page-table entry width
- `ADDR_W`, 5, RAM address width (32 entries)
- `VLAN_W`, 12, VLAN ID width
- `STARVE_LIMIT`, 4, consecutive lost arbitrations after which a pending lookup wins (range 1–15)

Ports:
- `clk` in 1: single clock
- `rst` in 1: reset, synchronous, active-high
- `vlan_in` in `VLAN_W`: lookup VLAN ID; the RAM address is `vlan_in[8:4]`
- `vlan_valid_in` in 1: lookup request valid
- `vlan_ready_out` out 1: lookup accepted this cycle
- `cfg_index` in 8: write index from the control-path parser
- `cfg_data` in `PAGE_W`: entry value to write
- `cfg_valid` in 1: write request valid
- `cfg_ready` out 1: write accepted this cycle
- `cfg_err` out 1: one-cycle pulse when a write is dropped (out-of-range index)
- `page_out` out `PAGE_W`: looked-up page base
- `page_valid_out` out 1: `page_out` valid
- `page_ready_in` in 1: downstream accepts the page
- `ram_addr` out `ADDR_W`: RAM address
- `ram_wr_en` out 1: RAM write strobe
- `ram_wr_data` out `PAGE_W`: RAM write data
- `ram_rd_en` out 1: RAM read strobe
- `ram_rd_data` in `PAGE_W`: RAM read data, valid one cycle after `ram_rd_en`
- `stat_lookups` out 32: lookup counter (see Configuration)
- `stat_writes` out 32: write counter
- `stat_stalls` out 32: output-stall cycle counter

## Operation
- **States:** IDLE, WR, RD_ISSUE, RD_WAIT, OUT.
- **Arbitration (IDLE only):**
  - Write wins when `cfg_valid` is high, unless `vlan_valid_in` is high and `starve_cnt == STARVE_LIMIT`; then the lookup wins.
  - `starve_cnt` increments on every IDLE cycle in which `vlan_valid_in` is high and the write wins. It saturates at `STARVE_LIMIT` and clears when a lookup is granted.
- **Handshakes:**
  - `cfg_ready` and `vlan_ready_out` are combinational. Each is high only in IDLE, only for the granted requester, and only when that requester's valid is high.
  - Neither ready is ever high outside IDLE, and the two are never high together.
- **Write grant:**
  - In-range index (`cfg_index[7:5] == 0`): next state WR. `ram_addr`, `ram_wr_data` and `ram_wr_en` are registered, so they assert in WR for exactly one cycle. WR then goes to IDLE.
  - Out-of-range index: the write is still accepted, no RAM write occurs, `cfg_err` pulses on the next cycle, and the state stays IDLE.
- **Lookup grant:** IDLE → RD_ISSUE (`ram_rd_en` = 1, `ram_addr = vlan_in[8:4]` as latched) → RD_WAIT (capture `ram_rd_data` into `page_out`) → OUT.
- **OUT:**
  - `page_valid_out` = 1.
  - `page_out` is held stable until `page_ready_in` is high.
  - Return to IDLE on the handshake cycle.
- **Idle RAM outputs:** `ram_wr_en` and `ram_rd_en` are 0 except in WR and RD_ISSUE respectively. `ram_addr` and `ram_wr_data` hold their last values.

## Timing
- **Lookup latency:** accept at cycle T; `ram_rd_en` at T+1; data at T+2; `page_valid_out` from T+3.
- **Throughput:** at best one lookup every 4 cycles, and one write every 2 cycles.
- **Write visibility:** a write accepted at T is visible to a lookup accepted at T+2 or later. The single state machine makes a same-cycle hazard impossible.
- **Reset:**
  - Every registered output goes to 0: `page_out`, `page_valid_out`, `ram_*`, `cfg_err`, stats. `starve_cnt` goes to 0 and the state to IDLE.
  - Combinational readies are 0 while `rst` is high.
  - Reset mid-operation aborts any in-flight lookup. It produces no `page_valid_out` and leaves RAM contents untouched.
- **Simultaneous requests:** when both valids are high, exactly one request is granted per IDLE cycle. The loser must keep its valid and data stable (standard valid/ready).

## Configuration
- **Macro:** `PAGE_TBL_ARB_STATS_EN`.
- **Defined:**
  - `stat_lookups` increments on each lookup handshake.
  - `stat_writes` increments on each WR cycle.
  - `stat_stalls` increments on each OUT cycle in which `page_ready_in` = 0.
  - All three are 32-bit wrap-around counters, cleared by reset.
- **Undefined:** the three stat outputs are tied to 0 and no counter flops are generated.

## Structure
- **Shared package `rmt_page_tbl_pkg`:** state enum encoding, `PAGE_TBL_DEPTH` = 32, the VLAN index slice constants (`VLAN_IDX_LSB` = 4, `VLAN_IDX_MSB` = 8), and `PAGE_W`.
- **Sub-module `page_tbl_starve_cnt`:** the saturating starvation counter plus grant decision, since it is reused by the stateful-memory arbiter. Everything else stays in one module.
- **RAM:** instantiated outside this block (`page_tbl_16w_32d` single-port variant).

## Test plan
- **Write then lookup:** write `cfg_index` = 0x03, `cfg_data` = 0xBEEF; then lookup `vlan_in` = 0x035 → `ram_wr_en` for 1 cycle at addr 3; `page_out` = 0xBEEF at T+3.
- **Out-of-range write:** `cfg_index` = 0x25 → `cfg_ready` = 1, `cfg_err` pulses once, `ram_wr_en` stays 0, and entry 5 is unchanged.
- **Starvation:** `cfg_valid` held high continuously with `vlan_valid_in` high, `STARVE_LIMIT` = 4 → exactly 4 writes, then the lookup is granted, then writes resume.
- **Output stall:** `page_ready_in` held low for 5 cycles → `page_out` stable, no new grants, `stat_stalls` = 5 with `PAGE_TBL_ARB_STATS_EN`.
- **Reset in RD_WAIT:** `rst` pulsed for 1 cycle → no `page_valid_out` and all outputs 0; a subsequent lookup returns the correct entry.
- **Macro off:** lookups and writes run; all `stat_*` read 0.
